// File: rtl/fma16_issue_ctrl.sv
`default_nettype none
// ============================================================================
// fma16_issue_ctrl : round-robin issue, op decode and tagged result return
//                    for one shared pipelined fma16 datapath.
// Revision 1.0
// ============================================================================
module fma16_issue_ctrl #(
  parameter int unsigned LAT  = 3,
  parameter logic [15:0] QNAN = 16'h7E00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [31:0] req_x_i,
  input  logic [31:0] req_y_i,
  input  logic [31:0] req_z_i,
  input  logic [1:0]  req_mul_i,
  input  logic [1:0]  req_add_i,
  input  logic [1:0]  req_negp_i,
  input  logic [1:0]  req_negz_i,
  input  logic [3:0]  req_rm_i,
  input  logic        drain_i,
  output logic [15:0] dp_x_o,
  output logic [15:0] dp_y_o,
  output logic [15:0] dp_z_o,
  output logic        dp_negp_o,
  output logic        dp_negz_o,
  output logic [1:0]  dp_rm_o,
  output logic        dp_adv_o,
  input  logic [15:0] dp_result_i,
  input  logic [3:0]  dp_flags_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_id_o,
  output logic [15:0] out_result_o,
  output logic [3:0]  out_flags_o,
  output logic        idle_o
);

  localparam logic [15:0] c_ONE = 16'h3C00;

  logic [LAT-1:0] v_q, v_d, tag_q, tag_d, byp_q, byp_d;
  logic           rr_q, rr_d;
  logic [15:0]    dp_x_q, dp_x_d, dp_y_q, dp_y_d, dp_z_q, dp_z_d;
  logic           dp_negp_q, dp_negp_d, dp_negz_q, dp_negz_d;
  logic [1:0]     dp_rm_q, dp_rm_d;
  logic           out_valid_q, out_valid_d, out_id_q, out_id_d;
  logic [15:0]    out_result_q, out_result_d;
  logic [3:0]     out_flags_q, out_flags_d;

  logic        w_adv, w_sel, w_fire, w_mul, w_add;
  logic [1:0]  w_elig, w_grant;
  logic [15:0] w_x, w_y, w_z;

  // Only a full output register facing a result ready to leave stalls the pipe.
  assign w_adv  = !(v_q[LAT-1] && out_valid_q && !out_ready_i);
  assign w_elig = req_valid_i & {2{w_adv && !drain_i}};

  always_comb begin
    w_grant = 2'b00;
    w_sel   = 1'b0;
    case (w_elig)
      2'b01: begin w_grant = 2'b01; w_sel = 1'b0; end
      2'b10: begin w_grant = 2'b10; w_sel = 1'b1; end
      2'b11: begin w_sel = rr_q; w_grant = rr_q ? 2'b10 : 2'b01; end
      default: ;
    endcase
  end

  assign w_fire = |w_grant;
  assign w_mul  = req_mul_i[w_sel];
  assign w_add  = req_add_i[w_sel];
  assign w_x    = w_sel ? req_x_i[31:16] : req_x_i[15:0];
  assign w_y    = w_sel ? req_y_i[31:16] : req_y_i[15:0];
  assign w_z    = w_sel ? req_z_i[31:16] : req_z_i[15:0];

  always_comb begin
    v_d          = v_q;
    tag_d        = tag_q;
    byp_d        = byp_q;
    rr_d         = rr_q;
    dp_x_d       = dp_x_q;
    dp_y_d       = dp_y_q;
    dp_z_d       = dp_z_q;
    dp_negp_d    = dp_negp_q;
    dp_negz_d    = dp_negz_q;
    dp_rm_d      = dp_rm_q;
    out_valid_d  = out_valid_q;
    out_id_d     = out_id_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;

    if (w_adv) begin
      v_d   = {v_q[LAT-2:0], w_fire};
      tag_d = {tag_q[LAT-2:0], w_sel};
      byp_d = {byp_q[LAT-2:0], w_fire && !w_mul && !w_add};
    end

    // A missing multiply becomes y=1.0, a missing add becomes z=+0.
    if (w_fire) begin
      rr_d      = !w_sel;
      dp_x_d    = w_x;
      dp_y_d    = w_mul ? w_y : c_ONE;
      dp_z_d    = w_add ? w_z : 16'h0000;
      dp_negp_d = req_negp_i[w_sel];
      dp_negz_d = req_negz_i[w_sel];
      dp_rm_d   = w_sel ? req_rm_i[3:2] : req_rm_i[1:0];
    end

    if (w_adv && v_q[LAT-1]) begin
      out_valid_d  = 1'b1;
      out_id_d     = tag_q[LAT-1];
      out_result_d = byp_q[LAT-1] ? QNAN : dp_result_i;
      out_flags_d  = byp_q[LAT-1] ? 4'b1000 : dp_flags_i;
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q          <= '0;
      tag_q        <= '0;
      byp_q        <= '0;
      rr_q         <= 1'b0;
      dp_x_q       <= 16'h0000;
      dp_y_q       <= 16'h0000;
      dp_z_q       <= 16'h0000;
      dp_negp_q    <= 1'b0;
      dp_negz_q    <= 1'b0;
      dp_rm_q      <= 2'b00;
      out_valid_q  <= 1'b0;
      out_id_q     <= 1'b0;
      out_result_q <= 16'h0000;
      out_flags_q  <= 4'h0;
    end else begin
      v_q          <= v_d;
      tag_q        <= tag_d;
      byp_q        <= byp_d;
      rr_q         <= rr_d;
      dp_x_q       <= dp_x_d;
      dp_y_q       <= dp_y_d;
      dp_z_q       <= dp_z_d;
      dp_negp_q    <= dp_negp_d;
      dp_negz_q    <= dp_negz_d;
      dp_rm_q      <= dp_rm_d;
      out_valid_q  <= out_valid_d;
      out_id_q     <= out_id_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign req_ready_o  = w_grant;
  assign dp_x_o       = dp_x_q;
  assign dp_y_o       = dp_y_q;
  assign dp_z_o       = dp_z_q;
  assign dp_negp_o    = dp_negp_q;
  assign dp_negz_o    = dp_negz_q;
  assign dp_rm_o      = dp_rm_q;
  assign dp_adv_o     = w_adv;
  assign out_valid_o  = out_valid_q;
  assign out_id_o     = out_id_q;
  assign out_result_o = out_result_q;
  assign out_flags_o  = out_flags_q;
  assign idle_o       = !(|v_q) && !out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fma16_issue_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fma16_issue_ctrl : vectors, directed corner sequences and random traffic
//                       scored against a transaction-level model.
// Revision 1.0
// ============================================================================
module tb_fma16_issue_ctrl;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req_valid = 2'b00, req_ready;
  logic [31:0] req_x = '0, req_y = '0, req_z = '0;
  logic [1:0] req_mul = '0, req_add = '0, req_negp = '0, req_negz = '0;
  logic [3:0] req_rm = '0;
  logic drain = 1'b0;
  logic [15:0] dp_x, dp_y, dp_z, dp_result;
  logic dp_negp, dp_negz, dp_adv;
  logic [1:0] dp_rm;
  logic [3:0] dp_flags;
  logic out_valid, out_ready = 1'b1, out_id, idle;
  logic [15:0] out_result;
  logic [3:0] out_flags;

  fma16_issue_ctrl #(.LAT(LAT), .QNAN(16'h7E00)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_x_i(req_x), .req_y_i(req_y), .req_z_i(req_z),
    .req_mul_i(req_mul), .req_add_i(req_add), .req_negp_i(req_negp), .req_negz_i(req_negz),
    .req_rm_i(req_rm), .drain_i(drain),
    .dp_x_o(dp_x), .dp_y_o(dp_y), .dp_z_o(dp_z), .dp_negp_o(dp_negp), .dp_negz_o(dp_negz),
    .dp_rm_o(dp_rm), .dp_adv_o(dp_adv), .dp_result_i(dp_result), .dp_flags_i(dp_flags),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_id_o(out_id),
    .out_result_o(out_result), .out_flags_o(out_flags), .idle_o(idle)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int out_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Stand-in datapath function; one known sample gives 1.0*2.0+1.0 = 3.0.
  function automatic logic [19:0] dp_fn(input logic [15:0] x, y, z,
                                        input logic np, nz, input logic [1:0] rm);
    logic [15:0] r;
    logic [3:0]  f;
    if (x == 16'h3C00 && y == 16'h4000 && z == 16'h3C00 && !np && !nz && rm == 2'd0)
      return {16'h4200, 4'h0};
    r = (x ^ {y[7:0], y[15:8]}) + z + {np, nz, rm, 12'h000};
    f = x[3:0] ^ y[7:4] ^ z[11:8] ^ {np, nz, rm};
    return {r, f};
  endfunction

  // Behavioural datapath: stages 1..LAT-1 advance with dp_adv.
  logic [19:0] pipe [1:LAT-1];
  always @(posedge clk) begin
    if (dp_adv) begin
      pipe[1] <= dp_fn(dp_x, dp_y, dp_z, dp_negp, dp_negz, dp_rm);
      for (int k = 2; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign dp_result = pipe[LAT-1][19:4];
  assign dp_flags  = pipe[LAT-1][3:0];

  typedef struct packed {
    logic        id;
    logic [15:0] res;
    logic [3:0]  fl;
  } exp_t;

  function automatic exp_t expect_op(input logic id, mul, add, input logic [15:0] x, y, z,
                                     input logic np, nz, input logic [1:0] rm);
    exp_t e;
    logic [19:0] r;
    e.id = id;
    if (!mul && !add) begin
      e.res = 16'h7E00;
      e.fl  = 4'b1000;
    end else begin
      r = dp_fn(x, mul ? y : 16'h3C00, add ? z : 16'h0000, np, nz, rm);
      e.res = r[19:4];
      e.fl  = r[3:0];
    end
    return e;
  endfunction

  // Transaction scoreboard: accepted ops queue up, results must leave in order.
  exp_t sb[$];
  logic rr_m = 1'b0;
  logic prev_hold = 1'b0;
  exp_t prev_out;
  always @(negedge clk) begin
    logic [1:0] exp_rdy;
    exp_t e;
    if (reset) begin
      sb.delete();
      rr_m = 1'b0;
      prev_hold = 1'b0;
    end else begin
      chk("idle", 32'(idle), 32'(sb.size() == 0));
      exp_rdy = 2'b00;
      if (dp_adv && !drain) begin
        case (req_valid)
          2'b01: exp_rdy = 2'b01;
          2'b10: exp_rdy = 2'b10;
          2'b11: exp_rdy = rr_m ? 2'b10 : 2'b01;
          default: exp_rdy = 2'b00;
        endcase
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (!(out_valid && !out_ready)) chk("dp_adv", 32'(dp_adv), 32'd1);
      if (prev_hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'({out_id, out_result, out_flags}), 32'(prev_out));
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = '{id: out_id, res: out_result, fl: out_flags};
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb.size() == 0) begin
          chk("spurious_out", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("out_word", 32'({out_id, out_result, out_flags}), 32'(e));
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back(expect_op(i[0], req_mul[i], req_add[i], req_x[i*16 +: 16],
                                 req_y[i*16 +: 16], req_z[i*16 +: 16], req_negp[i],
                                 req_negz[i], req_rm[i*2 +: 2]));
          rr_m = !i[0];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic mul, add, input logic [15:0] x, y, z,
                         input logic np, nz, input logic [1:0] rm);
    req_mul[r] = mul;  req_add[r] = add;
    req_x[r*16 +: 16] = x; req_y[r*16 +: 16] = y; req_z[r*16 +: 16] = z;
    req_negp[r] = np; req_negz[r] = nz; req_rm[r*2 +: 2] = rm;
  endtask

  task automatic rand_req(input int r);
    set_req(r, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom), 2'($urandom));
  endtask

  task automatic wait_out(input string name);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    chk({name, "_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (idle) return;
    end
    chk({name, "_idle_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic do_reset();
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
  endtask

  typedef struct {
    logic mul, add, np, nz;
    logic [1:0] rm;
    logic [15:0] x, y, z, ex, ey, ez;
    logic byp;
  } dec_vec_t;
  dec_vec_t dv [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    logic [19:0] r;
    int c0, hs_at, idle_at;

    dv[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 16'h1234, 16'h5678, 16'h9ABC, 16'h1234, 16'h5678, 16'h9ABC, 1'b0};
    dv[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 16'h4100, 16'hC200, 16'h7777, 16'h4100, 16'hC200, 16'h0000, 1'b0};
    dv[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 16'h3800, 16'h1111, 16'h4400, 16'h3800, 16'h3C00, 16'h4400, 1'b0};
    dv[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'hAAAA, 16'h5555, 16'h0F0F, 16'h0000, 16'h0000, 16'h0000, 1'b1};

    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_dp_ops", 32'({dp_x, dp_y}), 32'd0);
    chk("rst_dp_z", 32'(dp_z), 32'd0);
    chk("rst_out_word", 32'({out_id, out_result, out_flags}), 32'd0);
    chk("rst_adv", 32'(dp_adv), 32'd1);

    // Single op: latency LAT from the accepting edge.
    tick();
    set_req(0, 1'b1, 1'b1, 16'h3C00, 16'h4000, 16'h3C00, 1'b0, 1'b0, 2'd0);
    req_valid = 2'b01;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      chk("single_early", 32'(out_valid), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_word", 32'({out_id, out_result, out_flags}), 32'({1'b0, 16'h4200, 4'h0}));
    wait_idle("single");

    // Decode table, issued from requester 1.
    for (int i = 0; i < 4; i++) begin
      tick();
      set_req(1, dv[i].mul, dv[i].add, dv[i].x, dv[i].y, dv[i].z, dv[i].np, dv[i].nz, dv[i].rm);
      req_valid = 2'b10;
      @(negedge clk);
      chk("dec_ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = 2'b00;
      @(negedge clk);
      if (!dv[i].byp) begin
        chk("dec_dp_xy", 32'({dp_x, dp_y}), 32'({dv[i].ex, dv[i].ey}));
        chk("dec_dp_z", 32'(dp_z), 32'(dv[i].ez));
      end
      chk("dec_dp_ctl", 32'({dp_negp, dp_negz, dp_rm}), 32'({dv[i].np, dv[i].nz, dv[i].rm}));
      wait_out("dec");
      if (dv[i].byp) r = {16'h7E00, 4'b1000};
      else r = dp_fn(dv[i].ex, dv[i].ey, dv[i].ez, dv[i].np, dv[i].nz, dv[i].rm);
      chk("dec_result", 32'({out_id, out_result, out_flags}), 32'({1'b1, r}));
      wait_idle("dec");
    end

    // Contention from reset: alternating grants.
    do_reset();
    rand_req(0); rand_req(1);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      rand_req(0); rand_req(1);
    end
    req_valid = 2'b00;
    wait_idle("rr");

    // Backpressure: three back-to-back ops, consumer stalls 5 cycles.
    c0 = out_cnt;
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_req(1);
      req_valid = 2'b10;
      @(negedge clk);
      chk("bp_issue", 32'(req_ready), 32'h2);
      tick();
    end
    req_valid = 2'b00;
    wait_out("bp");
    held = out_result;
    tick();
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_adv", 32'(dp_adv), 32'd0);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_held", 32'(out_result), 32'(held));
      tick();
    end
    req_valid = 2'b00;
    out_ready = 1'b1;
    wait_idle("bp");
    chk("bp_count", 32'(out_cnt - c0), 32'd3);

    // Drain with two ops in flight.
    tick();
    rand_req(0); req_mul[0] = 1'b1;
    req_valid = 2'b01;
    tick();
    rand_req(1);
    req_valid = 2'b10;
    tick();
    drain = 1'b1;
    req_valid = 2'b11;
    c0 = out_cnt;
    hs_at = -10;
    idle_at = -1;
    for (int k = 0; k < 12 && idle_at < 0; k++) begin
      @(negedge clk);
      chk("drain_ready", 32'(req_ready), 32'd0);
      if (idle) idle_at = k;
      if (out_valid && out_ready) hs_at = k;
    end
    chk("drain_count", 32'(out_cnt - c0), 32'd2);
    chk("drain_idle_delay", 32'(idle_at - hs_at), 32'd1);
    tick();
    drain = 1'b0;
    req_valid = 2'b00;

    // Reset with ops in flight and a held result.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_req(0);
      req_valid = 2'b01;
      tick();
    end
    req_valid = 2'b00;
    wait_out("rstmid");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rstmid_valid", 32'(out_valid), 32'd0);
    chk("rstmid_idle", 32'(idle), 32'd1);
    c0 = out_cnt;
    repeat (8) @(negedge clk);
    chk("rstmid_no_stale", 32'(out_cnt - c0), 32'd0);
    tick();
    rand_req(0); rand_req(1);
    req_valid = 2'b11;
    @(negedge clk);
    chk("rstmid_tie", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    wait_idle("rstmid");

    // Random traffic against the scoreboard.
    for (int k = 0; k < 600; k++) begin
      tick();
      rand_req(0); rand_req(1);
      req_valid = 2'($urandom);
      drain     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    req_valid = 2'b00;
    drain = 1'b0;
    out_ready = 1'b1;
    wait_idle("rand");
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fma16_issue_ctrl.md
Name: fma16_issue_ctrl

Overview:
- Issue controller and arbiter that shares one pipelined fma16 datapath (multiply, align/add, normalize/round) between two requesters.
- Round-robin arbitration; decodes the mul/add op bits into datapath operands.
- Tracks valid/tag/bypass bits in lockstep with the datapath pipeline and returns tagged results through one output register with valid/ready backpressure.
- Sits between the core's FP issue logic and the fma16 datapath; owns the datapath's advance enable.

Parameters:
- LAT, 3, datapath depth in stages, including the controller's operand register as stage 0; legal range 2..8.
- QNAN, 16'h7E00, canonical NaN returned for illegal ops.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  2  per-requester request valid; bit i belongs to requester i
- req_ready  out  2  per-requester accept
- req_x, req_y, req_z  in  2x16 each  operands, packed {req1, req0}
- req_mul, req_add, req_negp, req_negz  in  2 each  op controls
- req_rm  in  2x2  rounding mode
- drain  in  1  blocks new issue while high
- dp_x, dp_y, dp_z  out  16 each  datapath operands (stage-0 register)
- dp_negp, dp_negz  out  1 each  datapath sign controls
- dp_rm  out  2  datapath rounding mode
- dp_adv  out  1  datapath pipeline advance enable
- dp_result  in  16  datapath stage LAT-1 result
- dp_flags  in  4  {NV,OF,UF,NX}
- out_valid  out  1  result valid
- out_ready  in  1  consumer accept
- out_id  out  1  requester that owns the result
- out_result  out  16  result
- out_flags  out  4  flags
- idle  out  1  pipeline and output register empty

Behaviour:
- Reset (synchronous): v[LAT-1:0]=0, tag=0, byp=0, out_valid=0, out_id=0, out_result=0, out_flags=0, rr pointer=0 (requester 0 wins the first tie), dp_* operand registers=0. Reset mid-operation discards all in-flight ops; no result is emitted for them.
- Stall:
  - adv = !(v[LAT-1] && out_valid && !out_ready); dp_adv = adv.
  - When adv=0, all stage registers, v/tag/byp and the operand register hold.
- Arbitration:
  - Eligible i = req_valid[i] && !drain && adv.
  - One eligible requester wins alone. Both eligible: winner is the one not granted last (the rr pointer).
  - req_ready[i]=1 only for the winner. req_ready is combinational from req_valid, drain, adv and the pointer; it never depends on req_ready itself.
  - The pointer updates only on an accepted handshake.
- Issue on edge E (handshake), from the winner's fields:
  - mul=1, add=1: dp_x=x, dp_y=y, dp_z=z.
  - mul=1, add=0: dp_z=16'h0000.
  - mul=0, add=1: dp_y=16'h3C00 (1.0).
  - mul=0, add=0: illegal. byp=1; operands are don't-care but still registered.
  - dp_negp/negz/rm are registered from the winner. v[0]=1, tag[0]=winner.
- Pipeline:
  - On adv, v/tag/byp shift stage k to k+1. With no issue, v[0]=0.
- Output register:
  - Loads on adv && v[LAT-1]: out_result/out_flags = byp ? {QNAN, 4'b1000} : {dp_result, dp_flags}; out_id = tag[LAT-1]; out_valid=1.
  - Else, out_valid clears when out_ready && out_valid.
  - Load and drain in the same cycle: the load wins, out_valid stays 1.
- Latency: accept at edge E gives out_valid=1 after edge E+LAT with no stall. Throughput is 1 op/cycle.
- Hold rule: out_result/out_id/out_flags hold stable while out_valid && !out_ready.
- drain:
  - Only blocks issue; in-flight ops complete normally.
  - idle = !(|v) && !out_valid.
- Simultaneous events: issue while stalled is impossible (req_ready=0). Issue and output load in the same cycle are independent.

Test Plan:
- Single op: req0 fma, x=16'h3C00, y=16'h4000, z=16'h3C00, rm=0, dp model returns 16'h4200/0000. Required: req_ready[0]=1 at E, out_valid after E+3, out_id=0, out_result=16'h4200.
- Contention: both valid for 4 cycles, pointer at reset. Required grants 0,1,0,1; results emerge in the same order with matching out_id; no cycle with both req_ready bits high.
- Backpressure: 3 back-to-back ops from req1, out_ready=0 for 5 cycles after the first result. Required: dp_adv=0 and req_ready=0 while stalled, out_result held; after release the 3 results arrive in order, none lost or duplicated.
- Decode: mul=1/add=0 gives dp_z=0000; mul=0/add=1 gives dp_y=3C00; mul=0/add=0 gives out_result=7E00, out_flags=4'b1000, with dp_result ignored.
- Drain: drain=1 with 2 ops in flight. Required: req_ready=0, both results still delivered, idle=1 one cycle after the last out handshake.
- Reset mid-op: assert reset with 2 ops in flight plus out_valid=1. Next cycle: out_valid=0, idle=1, no stale result afterwards; the first post-reset tie is granted to req0.
